apb_fir_cfg: RTL and testbench
==============================

// Module: apb_fir_cfg
// PURPOSE
//  Parametrised APB3 slave for FIR configuration: coefficient RAM, control/status registers and a start/done handshake.
//  Single clock domain (PCLK); the FIR engine reads coefficients through a dedicated port.
//  Adds the following: wait-stated coefficient reads, PSLVERR protection, sticky DONE with W1C, and a level IRQ.
// PARAMETERS
//  COEF_W      16  coefficient / PWDATA useful width (bits)
//  COEF_DEPTH  32  coefficient RAM depth (words); power of two
//  SAMP_W      14  width of sample-count register
//  CNT_W       $clog2(COEF_DEPTH)+1  width of coef-count register (derived, localparam)
// PORTS
//  PCLK           in   1       clock
//  PRESETn        in   1       async active-low reset
//  PADDR          in   32      byte address; only [11:0] decoded
//  PSELx          in   1       APB select
//  PENABLE        in   1       APB enable
//  PWRITE         in   1       1=write
//  PWDATA         in   32      write data; [COEF_W-1:0] used
//  PREADY         out  1       transfer complete
//  PRDATA         out  32      read data, zero-extended
//  PSLVERR        out  1       error, valid only with PREADY
//  fir_coef_addr  in   $clog2(COEF_DEPTH)  engine coefficient address
//  fir_coef_data  out  COEF_W  engine coefficient, 1-cycle sync read
//  fir_busy       in   1       engine running
//  fir_done       in   1       1-cycle pulse: run finished
//  start          out  1       1-cycle start pulse to engine
//  ile_wsp        out  CNT_W   number of coefficients
//  ile_probek     out  SAMP_W  number of samples
//  irq            out  1       done & irq_en (level)
// BEHAVIOUR
//  Map: 0x000 CTRL {[1]irq_en rw,[0]START wo}; 0x004 STATUS {[1]done w1c,[0]busy ro}; 0x008 ile_wsp rw;
//   0x00C ile_probek rw; 0x010 ID ro = {COEF_DEPTH[15:0],COEF_W[15:0]}; 0x400+4*i coef[i], i<COEF_DEPTH.
//  Reset: PREADY=0, PRDATA=0, PSLVERR=0, start=0, irq=0, ile_wsp=0, ile_probek=0, irq_en=0, done=0, FSM=IDLE.
//   RAM contents not reset; fir_coef_data undefined until first engine read.
//  FSM IDLE/WAIT/RESP. Decode at setup (PSELx&!PENABLE in IDLE):
//   coef read, no error -> WAIT (RAM read issued), next cycle -> RESP (PRDATA<=RAM); 1 wait state.
//   all else -> RESP; 0 wait states. RESP: PREADY=1 one cycle, then IDLE. PREADY low outside RESP.
//  Writes commit on the edge where PSELx&PENABLE&PREADY and PSLVERR=0.
//  PSLVERR=1 (no side effect, PRDATA=0) on: unmapped address; write to RO; any coef access while fir_busy;
//   START=1 while fir_busy or ile_wsp==0; ile_wsp write >COEF_DEPTH.
//  PSELx dropped before RESP: FSM -> IDLE, no write, no PREADY.
//  RAM single-port: engine owns address when fir_busy, APB otherwise; fir_coef_data = RAM[fir_coef_addr] one cycle later.
//  start: 1 cycle after START commit; busy bit mirrors fir_busy.
//  done: set on fir_done, cleared by writing 1 to STATUS[1]; simultaneous set+clear -> set wins. irq combinational from regs.
//  Width: ile_wsp/ile_probek take PWDATA LSBs; upper PWDATA bits ignored; reads zero-extend.
//  Async reset mid-transfer aborts it: no PREADY, no write, all outputs to reset values immediately.
// TESTING
//  Write 0x400..0x47C with 0x1000+i, read back -> each read PREADY low 1 cycle, PRDATA=0x1000+i, PSLVERR=0.
//  Write ile_wsp=5, START=1 -> start high exactly 1 cycle after commit; read STATUS while fir_busy=1 -> 0x1.
//  fir_busy=1, write coef 0x404 -> PSLVERR=1, coef[1] unchanged; fir_coef_addr=1 -> fir_coef_data old value next cycle.
//  irq_en=1, pulse fir_done -> irq=1; write STATUS=0x2 same cycle as fir_done -> done stays 1; later W1C -> irq=0.
//  Read 0x020, write ID, ile_wsp=33, START with ile_wsp=0 -> PSLVERR=1 each, registers unchanged.
//  Assert PRESETn=0 during WAIT -> PREADY=0 immediately, all regs reset; next transfer completes normally.

Source files
------------

// File: rtl/apb_fir_cfg_if.sv
// apb_fir_cfg_if: APB3 bus bundle between a master and the FIR configuration slave
interface apb_fir_cfg_if;
   logic [31:0] paddr;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] pwdata;
   logic        pready;
   logic [31:0] prdata;
   logic        pslverr;
   modport master (output paddr, psel, penable, pwrite, pwdata, input pready, prdata, pslverr);
   modport slave (input paddr, psel, penable, pwrite, pwdata, output pready, prdata, pslverr);
endinterface

// File: rtl/apb_fir_cfg.sv
// apb_fir_cfg: APB3 slave holding FIR coefficients, run parameters, start/done handshake and irq
module apb_fir_cfg #(
   parameter int COEF_W = 16,
   parameter int COEF_DEPTH = 32,
   parameter int SAMP_W = 14,
   localparam int CNT_W = $clog2(COEF_DEPTH) + 1,
   localparam int AW = $clog2(COEF_DEPTH)
) (
   input  logic              pclk_i,
   input  logic              presetn_i,
   apb_fir_cfg_if.slave      apb,
   input  logic [AW-1:0]     fir_coef_addr_i,
   output logic [COEF_W-1:0] fir_coef_data_o,
   input  logic              fir_busy_i,
   input  logic              fir_done_i,
   output logic              start_o,
   output logic [CNT_W-1:0]  ile_wsp_o,
   output logic [SAMP_W-1:0] ile_probek_o,
   output logic              irq_o
);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   localparam logic [9:0] COEF_LO = 10'h100;
   localparam logic [9:0] COEF_HI = 10'(256 + COEF_DEPTH);
   localparam logic [COEF_W-1:0] DEPTH_W = COEF_W'(COEF_DEPTH);
   state_t              state_q;
   logic [9:0]          word_q;
   logic                coef_q;
   logic                pready_q;
   logic                pslverr_q;
   logic [31:0]         prdata_q;
   logic                start_q;
   logic                irq_en_q;
   logic                done_q;
   logic [CNT_W-1:0]    ile_wsp_q;
   logic [SAMP_W-1:0]   ile_probek_q;
   logic [COEF_W-1:0]   ram [COEF_DEPTH];
   logic [COEF_W-1:0]   rd_q;
   logic [9:0]          word;
   logic                is_coef;
   logic                is_reg;
   logic                setup;
   logic                commit;
   logic                err_d;
   logic [31:0]         rdata_d;
   logic [AW-1:0]       ram_idx;
   logic [COEF_W-1:0]   rd_d;
   logic                unused_bits;
   always_comb begin
      word = apb.paddr[11:2];
      is_coef = word >= COEF_LO && word < COEF_HI;
      is_reg = word <= 10'd4;
      setup = state_q == IDLE && apb.psel && !apb.penable;
      commit = state_q == RESP && apb.psel && apb.penable && apb.pwrite && !pslverr_q;
      err_d = !(is_coef || is_reg) || (is_coef && fir_busy_i) ||
              (apb.pwrite && (word == 10'd4 ||
                 (word == 10'd0 && apb.pwdata[0] && (fir_busy_i || ile_wsp_q == '0)) ||
                 (word == 10'd2 && apb.pwdata[COEF_W-1:0] > DEPTH_W)));
      rdata_d = word == 10'd0 ? {30'b0, irq_en_q, 1'b0} :
                word == 10'd1 ? {30'b0, done_q, fir_busy_i} :
                word == 10'd2 ? 32'(ile_wsp_q) :
                word == 10'd3 ? 32'(ile_probek_q) :
                {16'(COEF_DEPTH), 16'(COEF_W)};
      // one RAM port: the engine owns the address whenever it is running
      ram_idx = fir_busy_i ? fir_coef_addr_i : word_q[AW-1:0];
      rd_d = ram[ram_idx];
   end
   assign unused_bits = ^{apb.paddr[31:12], apb.paddr[1:0], apb.pwdata[31:COEF_W]};
   assign apb.pready = pready_q;
   assign apb.prdata = prdata_q;
   assign apb.pslverr = pslverr_q;
   assign fir_coef_data_o = rd_q;
   assign start_o = start_q;
   assign ile_wsp_o = ile_wsp_q;
   assign ile_probek_o = ile_probek_q;
   assign irq_o = done_q & irq_en_q;
   always_ff @(posedge pclk_i) begin
      if (commit && coef_q) ram[word_q[AW-1:0]] <= apb.pwdata[COEF_W-1:0];
      rd_q <= rd_d;
   end
   always_ff @(posedge pclk_i or negedge presetn_i) begin
      if (!presetn_i) begin
         state_q <= IDLE;
         word_q <= '0;
         coef_q <= 1'b0;
         pready_q <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q <= '0;
         start_q <= 1'b0;
         irq_en_q <= 1'b0;
         done_q <= 1'b0;
         ile_wsp_q <= '0;
         ile_probek_q <= '0;
      end else begin
         start_q <= commit && word_q == 10'd0 && apb.pwdata[0];
         // a done pulse on the same edge as the W1C keeps the flag set
         done_q <= fir_done_i || (done_q && !(commit && word_q == 10'd1 && apb.pwdata[1]));
         if (commit && word_q == 10'd0) irq_en_q <= apb.pwdata[1];
         if (commit && word_q == 10'd2) ile_wsp_q <= apb.pwdata[CNT_W-1:0];
         if (commit && word_q == 10'd3) ile_probek_q <= apb.pwdata[SAMP_W-1:0];
         case (state_q)
            IDLE: if (setup) begin
               word_q <= word;
               coef_q <= is_coef;
               pslverr_q <= err_d;
               prdata_q <= (err_d || apb.pwrite || is_coef) ? '0 : rdata_d;
               state_q <= (is_coef && !apb.pwrite && !err_d) ? WAIT : RESP;
               pready_q <= !(is_coef && !apb.pwrite && !err_d);
            end
            WAIT: begin
               state_q <= apb.psel ? RESP : IDLE;
               pready_q <= apb.psel;
               if (apb.psel) prdata_q <= 32'(rd_d);
            end
            RESP: begin
               state_q <= IDLE;
               pready_q <= 1'b0;
               pslverr_q <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_apb_fir_cfg.sv
// tb_apb_fir_cfg: directed APB scoreboard bench for apb_fir_cfg
module tb_apb_fir_cfg;
   logic        pclk = 1'b0;
   logic        presetn = 1'b0;
   logic [4:0]  coef_addr = '0;
   logic [15:0] coef_data;
   logic        busy = 1'b0;
   logic        done = 1'b0;
   logic        start;
   logic        irq;
   logic [5:0]  wsp;
   logic [13:0] probek;
   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic        err;
      int          waits;
      logic        chk;
   } exp_t;
   exp_t sb[$];
   exp_t mon_e;
   int tests = 0;
   int fails = 0;
   int wcnt = 0;
   int start_cnt = 0;
   always #5 pclk = ~pclk;
   apb_fir_cfg_if bus();
   apb_fir_cfg dut (
      .pclk_i(pclk), .presetn_i(presetn), .apb(bus),
      .fir_coef_addr_i(coef_addr), .fir_coef_data_o(coef_data),
      .fir_busy_i(busy), .fir_done_i(done), .start_o(start),
      .ile_wsp_o(wsp), .ile_probek_o(probek), .irq_o(irq)
   );
   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask
   always @(negedge pclk) begin
      if (start) start_cnt++;
      if (!bus.psel) wcnt = 0;
      else if (bus.penable && !bus.pready) wcnt++;
      else if (bus.penable && bus.pready) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_pready: addr 0x%0h completed with no transfer expected", bus.paddr);
         end else begin
            mon_e = sb.pop_front();
            check($sformatf("pslverr@%0h", mon_e.addr), 32'(bus.pslverr), 32'(mon_e.err));
            check($sformatf("waits@%0h", mon_e.addr), wcnt, mon_e.waits);
            if (mon_e.chk) check($sformatf("prdata@%0h", mon_e.addr), bus.prdata, mon_e.data);
         end
      end
   end
   task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                       input logic [31:0] ed, input logic ee, input int ew, input logic pd = 1'b0);
      int n = 0;
      sb.push_back('{addr: a, data: ed, err: ee, waits: ew, chk: !w || ee});
      @(posedge pclk); #1;
      bus.psel = 1'b1; bus.penable = 1'b0; bus.paddr = a; bus.pwrite = w; bus.pwdata = d;
      @(posedge pclk); #1;
      bus.penable = 1'b1;
      while (!bus.pready && n < 8) begin
         @(posedge pclk); #1;
         n++;
      end
      if (!bus.pready) begin
         tests++;
         fails++;
         $display("FAIL timeout@%0h: no PREADY within 8 cycles", a);
         void'(sb.pop_back());
      end
      if (pd) done = 1'b1;
      @(posedge pclk); #1;
      done = 1'b0; bus.psel = 1'b0; bus.penable = 1'b0;
   endtask
   task automatic pulse_done();
      @(posedge pclk); #1 done = 1'b1;
      @(posedge pclk); #1 done = 1'b0;
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   initial begin
      bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = '0; bus.pwdata = '0;
      repeat (3) @(posedge pclk);
      #1;
      check("rst_pready", 32'(bus.pready), 0);
      check("rst_prdata", bus.prdata, 0);
      check("rst_pslverr", 32'(bus.pslverr), 0);
      check("rst_start", 32'(start), 0);
      check("rst_irq", 32'(irq), 0);
      check("rst_wsp", 32'(wsp), 0);
      check("rst_probek", 32'(probek), 0);
      #2 presetn = 1'b1;
      for (int i = 0; i < 32; i++) xfer(32'h400 + 32'(4 * i), 1'b1, 32'h1000 + 32'(i), 0, 1'b0, 0);
      for (int i = 0; i < 32; i++) xfer(32'h400 + 32'(4 * i), 1'b0, 0, 32'h1000 + 32'(i), 1'b0, 1);
      xfer(32'h010, 1'b0, 0, 32'h0020_0010, 1'b0, 0);
      xfer(32'h00C, 1'b1, 32'h7FFF_3ABC, 0, 1'b0, 0);
      check("probek_port", 32'(probek), 32'h3ABC);
      xfer(32'h00C, 1'b0, 0, 32'h3ABC, 1'b0, 0);
      xfer(32'h000, 1'b1, 32'h1, 0, 1'b1, 0);
      xfer(32'h008, 1'b1, 32'd33, 0, 1'b1, 0);
      xfer(32'h008, 1'b0, 0, 0, 1'b0, 0);
      xfer(32'h008, 1'b1, 32'hFFFF_0005, 0, 1'b0, 0);
      xfer(32'h008, 1'b0, 0, 32'd5, 1'b0, 0);
      check("wsp_port", 32'(wsp), 5);
      xfer(32'h010, 1'b1, 32'h1234, 0, 1'b1, 0);
      xfer(32'h010, 1'b0, 0, 32'h0020_0010, 1'b0, 0);
      xfer(32'h020, 1'b0, 0, 0, 1'b1, 0);
      xfer(32'h480, 1'b0, 0, 0, 1'b1, 0);
      xfer(32'h800, 1'b0, 0, 0, 1'b1, 0);
      check("start_cnt_pre", start_cnt, 0);
      xfer(32'h000, 1'b1, 32'h1, 0, 1'b0, 0);
      check("start_pulse", 32'(start), 1);
      @(posedge pclk); #1;
      check("start_fall", 32'(start), 0);
      check("start_cnt", start_cnt, 1);
      busy = 1'b1;
      xfer(32'h004, 1'b0, 0, 32'h1, 1'b0, 0);
      xfer(32'h404, 1'b1, 32'hDEAD, 0, 1'b1, 0);
      xfer(32'h404, 1'b0, 0, 0, 1'b1, 0);
      xfer(32'h000, 1'b1, 32'h1, 0, 1'b1, 0);
      coef_addr = 5'd1;
      @(posedge pclk); #1;
      check("coef_data_1", 32'(coef_data), 32'h1001);
      coef_addr = 5'd31;
      @(posedge pclk); #1;
      check("coef_data_31", 32'(coef_data), 32'h101F);
      busy = 1'b0;
      check("start_cnt_busy", start_cnt, 1);
      xfer(32'h404, 1'b0, 0, 32'h1001, 1'b0, 1);
      xfer(32'h000, 1'b1, 32'h2, 0, 1'b0, 0);
      check("irq_before_done", 32'(irq), 0);
      pulse_done();
      check("irq_after_done", 32'(irq), 1);
      xfer(32'h004, 1'b0, 0, 32'h2, 1'b0, 0);
      xfer(32'h000, 1'b0, 0, 32'h2, 1'b0, 0);
      xfer(32'h004, 1'b1, 32'h2, 0, 1'b0, 0, 1'b1);
      check("irq_set_wins", 32'(irq), 1);
      xfer(32'h004, 1'b1, 32'h2, 0, 1'b0, 0);
      check("irq_w1c", 32'(irq), 0);
      xfer(32'h004, 1'b0, 0, 0, 1'b0, 0);
      @(posedge pclk); #1;
      bus.psel = 1'b1; bus.penable = 1'b0; bus.paddr = 32'h408; bus.pwrite = 1'b0;
      @(posedge pclk); #1;
      bus.penable = 1'b1;
      check("abort_wait_state", 32'(bus.pready), 0);
      bus.psel = 1'b0; bus.penable = 1'b0;
      repeat (2) begin
         @(posedge pclk); #1;
         check("abort_no_pready", 32'(bus.pready), 0);
      end
      xfer(32'h408, 1'b0, 0, 32'h1002, 1'b0, 1);
      pulse_done();
      check("irq_pre_reset", 32'(irq), 1);
      @(posedge pclk); #1;
      bus.psel = 1'b1; bus.penable = 1'b0; bus.paddr = 32'h40C; bus.pwrite = 1'b0;
      @(posedge pclk); #1;
      bus.penable = 1'b1;
      #2 presetn = 1'b0;
      #1;
      check("rstw_pready", 32'(bus.pready), 0);
      check("rstw_pslverr", 32'(bus.pslverr), 0);
      check("rstw_prdata", bus.prdata, 0);
      check("rstw_wsp", 32'(wsp), 0);
      check("rstw_probek", 32'(probek), 0);
      check("rstw_irq", 32'(irq), 0);
      bus.psel = 1'b0; bus.penable = 1'b0;
      @(posedge pclk); #3 presetn = 1'b1;
      xfer(32'h40C, 1'b0, 0, 32'h1003, 1'b0, 1);
      xfer(32'h008, 1'b0, 0, 0, 1'b0, 0);
      xfer(32'h000, 1'b0, 0, 0, 1'b0, 0);
      xfer(32'h004, 1'b0, 0, 0, 1'b0, 0);
      repeat (3) @(posedge pclk);
      #1;
      check("sb_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
